// File: rtl/ec_point_add_dbl_if.sv
// Request/result bundle for ec_point_add_dbl: operands and mode in, busy/done and result out.
interface ec_point_add_dbl_if #(
    parameter int N = 10
);
    logic         start;
    logic         mode;
    logic [N-1:0] p;
    logic [N-1:0] x1;
    logic [N-1:0] y1;
    logic [N-1:0] x2;
    logic [N-1:0] y2;
    logic         inf1;
    logic         inf2;
    logic         busy;
    logic         done;
    logic [N-1:0] x3;
    logic [N-1:0] y3;
    logic         infinity;
    logic         error;

    modport master (
        output start, mode, p, x1, y1, x2, y2, inf1, inf2,
        input  busy, done, x3, y3, infinity, error
    );

    modport slave (
        input  start, mode, p, x1, y1, x2, y2, inf1, inf2,
        output busy, done, x3, y3, infinity, error
    );
endinterface

// File: rtl/ec_point_add_dbl.sv
// Affine EC point add/double mod p: special cases finish in 2 cycles, general case <= 8N+16 cycles; start ignored while busy.
// ECC_AUTO_DOUBLE_EN: add with P == Q is computed as a doubling instead of flagging error.
module ec_point_add_dbl #(
    parameter int N      = 10,
    parameter int A_COEF = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ec_point_add_dbl_if.slave     bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_NUM, S_INV, S_LAMBDA, S_XR, S_YR, S_DONE
    } state_t;

    state_t         state_q;
    logic           mode_q, inf1_q, inf2_q;
    logic [N-1:0]   p_q, x1_q, y1_q, x2_q, y2_q;
    logic [N-1:0]   num_q, u_q, v_q, r_q, s_q, lam_q, xt_q;
    logic [N-1:0]   mul_a_q, mul_b_q, mul_acc_q;
    logic [CW-1:0]  mul_cnt_q;
    logic           busy_q, done_q, inf_q, err_q;
    logic [N-1:0]   x3_q, y3_q;

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] m);
        logic [N:0] s;
        logic [N:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = s - {1'b0, m};
        return d[N] ? s[N-1:0] : d[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] m);
        return (a >= b) ? (a - b) : (a - b + m);
    endfunction

    // (a + m) / 2 for odd a, written without the carry bit since a and m are both odd
    function automatic logic [N-1:0] mod_half(input logic [N-1:0] a, input logic [N-1:0] m);
        return a[0] ? ((a >> 1) + (m >> 1) + N'(1)) : (a >> 1);
    endfunction

    logic [N-1:0] a_red_d, mul_dbl_d, mul_d, x2_eff_d, num_dbl_d, den_dbl_d, x3_d, y3_d;
    logic         mul_last_d;

    assign a_red_d    = N'({{N{1'b0}}, 32'(A_COEF)} % {32'd0, p_q});
    assign mul_dbl_d  = mod_add(mul_acc_q, mul_acc_q, p_q);
    assign mul_d      = mul_b_q[mul_cnt_q] ? mod_add(mul_dbl_d, mul_a_q, p_q) : mul_dbl_d;
    assign mul_last_d = (mul_cnt_q == '0);
    assign x2_eff_d   = mode_q ? x1_q : x2_q;
    assign num_dbl_d  = mod_add(mod_add(mod_add(mul_d, mul_d, p_q), mul_d, p_q), a_red_d, p_q);
    assign den_dbl_d  = mod_add(y1_q, y1_q, p_q);
    assign x3_d       = mod_sub(mod_sub(mul_d, x1_q, p_q), x2_eff_d, p_q);
    assign y3_d       = mod_sub(mul_d, y1_q, p_q);

    logic         chk_fin_d, chk_inf_d, chk_err_d, chk_dbl_d;
    logic [N-1:0] chk_x_d, chk_y_d;

    always_comb begin
        chk_fin_d = 1'b1;
        chk_inf_d = 1'b1;
        chk_err_d = 1'b0;
        chk_dbl_d = 1'b0;
        chk_x_d   = '0;
        chk_y_d   = '0;
        if (!mode_q && inf1_q) begin
            chk_inf_d = inf2_q;
            chk_x_d   = inf2_q ? '0 : x2_q;
            chk_y_d   = inf2_q ? '0 : y2_q;
        end else if (!mode_q && inf2_q) begin
            chk_inf_d = 1'b0;
            chk_x_d   = x1_q;
            chk_y_d   = y1_q;
        end else if (mode_q && inf1_q) begin
            chk_inf_d = 1'b1;
        end else if (!mode_q && x1_q == x2_q && mod_add(y1_q, y2_q, p_q) == '0) begin
            chk_inf_d = 1'b1;
        end else if (mode_q && y1_q == '0) begin
            chk_inf_d = 1'b1;
        end else if (!mode_q && x1_q == x2_q) begin
`ifdef ECC_AUTO_DOUBLE_EN
            if (y1_q == y2_q) begin
                chk_fin_d = 1'b0;
                chk_dbl_d = 1'b1;
            end else begin
                chk_inf_d = 1'b0;
                chk_err_d = 1'b1;
            end
`else
            chk_inf_d = 1'b0;
            chk_err_d = 1'b1;
`endif
        end else begin
            chk_fin_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x3_q    <= '0;
            y3_q    <= '0;
            inf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        p_q     <= bus.p;
                        x1_q    <= bus.x1;
                        y1_q    <= bus.y1;
                        x2_q    <= bus.x2;
                        y2_q    <= bus.y2;
                        inf1_q  <= bus.inf1;
                        inf2_q  <= bus.inf2;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    mul_a_q   <= x1_q;
                    mul_b_q   <= x1_q;
                    mul_acc_q <= '0;
                    mul_cnt_q <= CW'(N - 1);
                    if (chk_fin_d) begin
                        x3_q    <= chk_x_d;
                        y3_q    <= chk_y_d;
                        inf_q   <= chk_inf_d;
                        err_q   <= chk_err_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        mode_q  <= mode_q | chk_dbl_d;
                        state_q <= S_NUM;
                    end
                end
                S_NUM: begin
                    v_q <= p_q;
                    r_q <= N'(1);
                    s_q <= '0;
                    if (mode_q) begin
                        mul_acc_q <= mul_d;
                        mul_cnt_q <= mul_cnt_q - CW'(1);
                        if (mul_last_d) begin
                            num_q   <= num_dbl_d;
                            u_q     <= den_dbl_d;
                            state_q <= S_INV;
                        end
                    end else begin
                        num_q   <= mod_sub(y2_q, y1_q, p_q);
                        u_q     <= mod_sub(x2_q, x1_q, p_q);
                        state_q <= S_INV;
                    end
                end
                S_INV: begin
                    // invariants: r*den == u and s*den == v (mod p)
                    if (u_q == N'(1) || v_q == N'(1)) begin
                        mul_a_q   <= num_q;
                        mul_b_q   <= (u_q == N'(1)) ? r_q : s_q;
                        mul_acc_q <= '0;
                        mul_cnt_q <= CW'(N - 1);
                        state_q   <= S_LAMBDA;
                    end else if (!u_q[0]) begin
                        u_q <= u_q >> 1;
                        r_q <= mod_half(r_q, p_q);
                    end else if (!v_q[0]) begin
                        v_q <= v_q >> 1;
                        s_q <= mod_half(s_q, p_q);
                    end else if (u_q >= v_q) begin
                        u_q <= (u_q - v_q) >> 1;
                        r_q <= mod_half(mod_sub(r_q, s_q, p_q), p_q);
                    end else begin
                        v_q <= (v_q - u_q) >> 1;
                        s_q <= mod_half(mod_sub(s_q, r_q, p_q), p_q);
                    end
                end
                S_LAMBDA, S_XR, S_YR: begin
                    mul_acc_q <= mul_d;
                    mul_cnt_q <= mul_cnt_q - CW'(1);
                    if (mul_last_d) begin
                        mul_acc_q <= '0;
                        mul_cnt_q <= CW'(N - 1);
                        if (state_q == S_LAMBDA) begin
                            lam_q   <= mul_d;
                            mul_a_q <= mul_d;
                            mul_b_q <= mul_d;
                            state_q <= S_XR;
                        end else if (state_q == S_XR) begin
                            xt_q    <= x3_d;
                            mul_a_q <= lam_q;
                            mul_b_q <= mod_sub(x1_q, x3_d, p_q);
                            state_q <= S_YR;
                        end else begin
                            x3_q    <= xt_q;
                            y3_q    <= y3_d;
                            inf_q   <= 1'b0;
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.x3       = x3_q;
    assign bus.y3       = y3_q;
    assign bus.infinity = inf_q;
    assign bus.error    = err_q;
endmodule

// File: tb/tb_ec_point_add_dbl.sv
// Directed vectors on y^2 = x^3 + 2x + 2 mod 17 plus reset/busy/done-cycle sequences.
module tb_ec_point_add_dbl;
    localparam int N       = 10;
    localparam int LAT_MAX = 8 * N + 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ec_point_add_dbl_if #(.N(N)) bus ();

    ec_point_add_dbl #(.N(N), .A_COEF(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         mode;
        logic [N-1:0] x1, y1, x2, y2;
        logic         inf1, inf2;
        logic [N-1:0] ex, ey;
        logic         einf, eerr;
        int           maxlat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic md, input int ax, input int ay, input int bx,
                                input int by, input logic i1, input logic i2, input int ex,
                                input int ey, input logic einf, input logic eerr, input int lat);
        vec_t v;
        v.mode = md;   v.x1 = N'(ax); v.y1 = N'(ay); v.x2 = N'(bx); v.y2 = N'(by);
        v.inf1 = i1;   v.inf2 = i2;   v.ex = N'(ex); v.ey = N'(ey);
        v.einf = einf; v.eerr = eerr; v.maxlat = lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.mode = v.mode; bus.p = N'(17);
        bus.x1 = v.x1; bus.y1 = v.y1; bus.x2 = v.x2; bus.y2 = v.y2;
        bus.inf1 = v.inf1; bus.inf2 = v.inf2;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int cyc);
        check({tag, "_done_in_time"}, 32'(bus.done === 1'b1 && cyc <= v.maxlat), 1);
        check({tag, "_x3"}, 32'(bus.x3), 32'(v.ex));
        check({tag, "_y3"}, 32'(bus.y3), 32'(v.ey));
        check({tag, "_inf"}, 32'(bus.infinity), 32'(v.einf));
        check({tag, "_err"}, 32'(bus.error), 32'(v.eerr));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    cyc;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        // operands are registered, so disturbing the inputs must not matter
        bus.mode = ~v.mode; bus.inf1 = ~v.inf1; bus.inf2 = ~v.inf2;
        bus.x1 = N'($urandom_range(0, 16)); bus.y1 = N'($urandom_range(0, 16));
        bus.x2 = N'($urandom_range(0, 16)); bus.y2 = N'($urandom_range(0, 16));
        wait_done(LAT_MAX + 4, cyc);
        check_result(tag, v, cyc);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 0);
        check({tag, "_x3_hold"}, 32'(bus.x3), 32'(v.ex));
    endtask

    initial begin
        int   cyc;
        logic saw;
        vec_t v;

        vecs[0]  = mk(0, 11, 4, 6, 8, 0, 0, 2, 16, 0, 0, LAT_MAX);
        vecs[1]  = mk(1, 5, 1, 0, 0, 0, 0, 6, 3, 0, 0, LAT_MAX);
        vecs[2]  = mk(0, 5, 1, 6, 3, 0, 0, 10, 6, 0, 0, LAT_MAX);
        vecs[3]  = mk(0, 5, 1, 5, 16, 0, 0, 0, 0, 1, 0, 3);
        vecs[4]  = mk(0, 5, 1, 6, 3, 1, 0, 6, 3, 0, 0, 3);
        vecs[5]  = mk(0, 10, 6, 1, 1, 0, 1, 10, 6, 0, 0, 3);
        vecs[6]  = mk(1, 5, 1, 6, 3, 1, 0, 0, 0, 1, 0, 3);
        vecs[7]  = mk(1, 3, 0, 6, 3, 0, 0, 0, 0, 1, 0, 3);
        vecs[8]  = mk(0, 5, 1, 6, 3, 1, 1, 0, 0, 1, 0, 3);
        vecs[9]  = mk(0, 6, 3, 10, 6, 0, 0, 9, 16, 0, 0, LAT_MAX);
        vecs[10] = mk(1, 6, 3, 0, 0, 0, 0, 3, 1, 0, 0, LAT_MAX);
`ifdef ECC_AUTO_DOUBLE_EN
        vecs[11] = mk(0, 5, 1, 5, 1, 0, 0, 6, 3, 0, 0, LAT_MAX);
`else
        vecs[11] = mk(0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 1, 3);
`endif

        bus.start = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_x3", 32'(bus.x3), 0);
        check("rst_y3", 32'(bus.y3), 0);
        check("rst_inf", 32'(bus.infinity), 0);
        check("rst_err", 32'(bus.error), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // reset 20 cycles into a doubling, over non-zero held outputs
        run_vec(vecs[1], 100);
        @(negedge clk);
        drive(vecs[1]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_busy_before_rst", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_x3", 32'(bus.x3), 0);
        check("mid_rst_y3", 32'(bus.y3), 0);
        check("mid_rst_inf", 32'(bus.infinity), 0);
        check("mid_rst_err", 32'(bus.error), 0);
        saw = 1'b0;
        repeat (N * 8) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
        end
        check("mid_rst_no_resume", 32'(saw), 0);
        run_vec(vecs[1], 101);

        // a start pulse while busy must not disturb or queue a second operation
        @(negedge clk);
        drive(vecs[0]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        drive(vecs[1]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(LAT_MAX, cyc);
        v = vecs[0];
        check_result("busy_start", v, cyc);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw = 1'b1;
        end
        check("busy_start_not_queued", 32'(saw), 0);

        // start held high across done: ignored in the done cycle, accepted one cycle later
        drive(vecs[1]);
        bus.start = 1'b1;
        @(negedge clk);
        wait_done(LAT_MAX + 4, cyc);
        check_result("held_start", vecs[1], cyc);
        @(negedge clk);
        check("held_start_ignored_busy", 32'(bus.busy), 0);
        check("held_start_ignored_done", 32'(bus.done), 0);
        @(negedge clk);
        check("held_start_accepted", 32'(bus.busy), 1);
        bus.start = 1'b0;
        wait_done(LAT_MAX + 4, cyc);
        check_result("held_start_2nd", vecs[1], cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ec_point_add_dbl.md
EC_POINT_ADD_DBL -- requirements
Module: ec_point_add_dbl

Interface
REQ-001 Parameter N, default 10: field element width in bits; legal range 4..256.
REQ-002 Parameter A_COEF, default 2: curve coefficient a of y^2 = x^3 + a*x + b, reduced mod p on use.
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 mode  input  1  0 = add P+Q, 1 = double 2P (Q ignored).
REQ-007 p  input  N  odd prime modulus, 3 < p < 2^N, held stable while busy.
REQ-008 x1, y1, x2, y2  input  N each  affine coordinates of P and Q, each < p.
REQ-009 inf1, inf2  input  1 each  P (resp. Q) is the point at infinity.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse when results are valid.
REQ-012 x3, y3  output  N each  result coordinates.
REQ-013 infinity  output  1  result is the point at infinity.
REQ-014 error  output  1  result invalid (see REQ-028).

Function
REQ-015 On start in IDLE, the block SHALL register mode, p, x1, y1, x2, y2, inf1, inf2 and set busy the next cycle.
REQ-016 While busy, start SHALL be ignored and input changes SHALL NOT affect the result.
REQ-017 States: IDLE -> CHECK -> NUM -> INV -> LAMBDA -> XR -> YR -> DONE -> IDLE; CHECK may go directly to DONE for special cases.
REQ-018 CHECK special cases, highest priority first: add with inf1 -> result = Q; add with inf2 -> result = P; double with inf1 -> infinity; add with x1 == x2 and (y1 + y2) mod p == 0 -> infinity; double with y1 == 0 -> infinity.
REQ-019 Add lambda SHALL be (y2 - y1) * (x2 - x1)^-1 mod p; double lambda SHALL be (3*x1^2 + A_COEF) * (2*y1)^-1 mod p.
REQ-020 x3 SHALL be (lambda^2 - x1 - x2) mod p for add and (lambda^2 - 2*x1) mod p for double; y3 SHALL be (lambda*(x1 - x3) - y1) mod p.
REQ-021 Modular add/sub SHALL use N+1-bit intermediates with one conditional correction; all results SHALL be fully reduced (< p).
REQ-022 Modular multiply SHALL be iterative shift-add, one bit per cycle, N cycles; inverse SHALL be binary extended Euclid, at most 2N iterations.
REQ-023 done SHALL assert no later than 8*N + 16 cycles after start is accepted; special cases SHALL complete within 3 cycles.
REQ-024 In DONE, done = 1 for exactly one cycle, busy falls in the same cycle, and x3/y3/infinity/error SHALL hold until the next accepted start.
REQ-025 When infinity = 1, x3 and y3 SHALL be 0.
REQ-026 start asserted in the same cycle as done SHALL be ignored; it is accepted the following cycle if still high.

Reset
REQ-027 reset = 1 at any clock edge, including mid-operation, SHALL abort the operation, return to IDLE and clear busy, done, x3, y3, infinity and error to 0; reset overrides start.

Configuration
REQ-028 Macro ECC_AUTO_DOUBLE_EN: if defined, add mode with x1 == x2, y1 == y2 != 0 and neither input infinite SHALL be computed as a doubling; if undefined, that case SHALL end in DONE with error = 1, infinity = 0, x3 = y3 = 0.

Verification (p = 17, A_COEF = 2, N = 10)
REQ-029 add (11,4) + (6,8) -> done with x3 = 2, y3 = 16, infinity = 0, within 96 cycles.
REQ-030 double (5,1) -> (6,3); then add (5,1) + (6,3) -> (10,6).
REQ-031 add (5,1) + (5,16) -> infinity = 1, x3 = y3 = 0; add with inf1 = 1, Q = (6,3) -> (6,3).
REQ-032 add (5,1) + (5,1) -> (6,3) with ECC_AUTO_DOUBLE_EN defined; error = 1 without it.
REQ-033 reset pulsed 20 cycles into a doubling -> busy = 0 and all outputs 0 next cycle; a fresh start then completes correctly; a start pulse while busy has no effect.
